mem_access_unit: RTL

//  Load/store unit of the core. Takes one LOAD/STORE request from execute and drives
//  a single-outstanding 32-bit word bus toward data memory. For loads it returns

---
 rtl/mem_access_unit.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit: one request at a time, single-outstanding word bus toward data
// memory, formatted load data or error code returned on the response channel.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_op_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [4:0]        req_rd_i,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic              mem_we_o,
  output logic [ADDR_W-3:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [4:0]        rsp_rd_o,
  output logic [31:0]       rsp_data_o,
  output logic [1:0]        rsp_err_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

  state_e            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              op_q, op_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [4:0]        rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              mem_valid_q, mem_valid_d, mem_we_q, mem_we_d;
  logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [4:0]        rsp_rd_q, rsp_rd_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic [1:0]        rsp_err_q, rsp_err_d;

  logic        legal, misal, to_hit;
  logic [3:0]  be;
  logic [31:0] wdata, lane, ldata;

  // Request decode: funct3[1:0] is the access size for both loads and stores.
  always_comb begin
    legal = (req_funct3_i == 3'b000) || (req_funct3_i == 3'b001) || (req_funct3_i == 3'b010) ||
            (!req_op_i && ((req_funct3_i == 3'b100) || (req_funct3_i == 3'b101)));
    misal = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
            ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
    case (req_funct3_i[1:0])
      2'b00:   begin be = 4'b0001 << req_addr_i[1:0]; wdata = {4{req_wdata_i[7:0]}};  end
      2'b01:   begin be = 4'b0011 << req_addr_i[1:0]; wdata = {2{req_wdata_i[15:0]}}; end
      default: begin be = 4'b1111;                    wdata = req_wdata_i;            end
    endcase
  end

  always_comb begin
    lane = mem_rdata_i >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ldata = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ldata = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ldata = {24'b0, lane[7:0]};
      3'b101:  ldata = {16'b0, lane[15:0]};
      default: ldata = lane;
    endcase
  end

  // Count runs 0..TIMEOUT-1 over the BUS cycles, so mem_valid is up for TIMEOUT cycles.
  assign to_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    op_d        = op_q;
    f3_d        = f3_q;
    off_d       = off_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rd_d    = rsp_rd_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i && req_ready_q) begin
          req_ready_d = 1'b0;
          op_d        = req_op_i;
          f3_d        = req_funct3_i;
          off_d       = req_addr_i[1:0];
          rd_d        = req_rd_i;
          if (!legal || misal) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = !legal ? 2'd2 : 2'd1;
            rsp_rd_d    = 5'd0;
            rsp_data_d  = 32'd0;
          end else begin
            state_d     = BUS;
            cnt_d       = '0;
            mem_valid_d = 1'b1;
            mem_we_d    = req_op_i;
            mem_addr_d  = req_addr_i[ADDR_W-1:2];
            mem_be_d    = be;
            mem_wdata_d = wdata;
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      BUS: begin
        if (mem_ready_i) begin
          state_d     = RESP;
          mem_valid_d = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 2'd0;
          rsp_rd_d    = op_q ? 5'd0 : rd_q;
          rsp_data_d  = op_q ? 32'd0 : ldata;
        end else if (to_hit) begin
          state_d     = RESP;
          mem_valid_d = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 2'd3;
          rsp_rd_d    = 5'd0;
          rsp_data_d  = 32'd0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      op_q        <= 1'b0;
      f3_q        <= 3'd0;
      off_q       <= 2'd0;
      rd_q        <= 5'd0;
      cnt_q       <= '0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rd_q    <= 5'd0;
      rsp_data_q  <= 32'd0;
      rsp_err_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      op_q        <= op_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign mem_valid_o = mem_valid_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rd_o    = rsp_rd_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;

endmodule
